// File: rtl/pc_seq_if.sv
// Control-side bundle for the PC sequencer: operation request, flags, IR fields
// and the sequencer's observable state.
interface pc_seq_if #(
  parameter int AW       = 12,
  parameter int DW       = 8,
  parameter int RS_DEPTH = 8,
  parameter int IS_DEPTH = 2
);
  logic                            clkEn_i;
  logic [3:0]                      PCoper_i;
  logic                            PCEn_c;
  logic                            carry_i;
  logic                            zero_i;
  logic [DW-1:0]                   disp_i;
  logic [AW-1:0]                   addr_i;
  logic [AW-1:0]                   PC_o;
  logic                            ccC_o;
  logic                            ccZ_o;
  logic [$clog2(RS_DEPTH+1)-1:0]   rsDepth_o;
  logic [$clog2(IS_DEPTH+1)-1:0]   isDepth_o;
  logic                            stkErr_o;

  modport master (
    output clkEn_i, PCoper_i, PCEn_c, carry_i, zero_i, disp_i, addr_i,
    input  PC_o, ccC_o, ccZ_o, rsDepth_o, isDepth_o, stkErr_o
  );

  modport slave (
    input  clkEn_i, PCoper_i, PCEn_c, carry_i, zero_i, disp_i, addr_i,
    output PC_o, ccC_o, ccZ_o, rsDepth_o, isDepth_o, stkErr_o
  );
endinterface

// File: rtl/pc_seq_unit.sv
// Program counter sequencer: increment, jumps, conditional relative branches,
// subroutine return stack and interrupt context stack with sticky stack error.
module pc_seq_unit #(
  parameter int             AW       = 12,
  parameter int             DW       = 8,
  parameter int             RS_DEPTH = 8,
  parameter int             IS_DEPTH = 2,
  parameter logic [AW-1:0]  ISR_VEC  = AW'(12'h001)
) (
  input  logic        clk_i,
  input  logic        rst,
  pc_seq_if.slave     bus
);
  localparam int RSW  = $clog2(RS_DEPTH+1);
  localparam int ISW  = $clog2(IS_DEPTH+1);
  localparam int RSIW = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;
  localparam int ISIW = (IS_DEPTH > 1) ? $clog2(IS_DEPTH) : 1;

  typedef enum logic [3:0] {
    OP_INC  = 4'd0,
    OP_JMP  = 4'd1,
    OP_BZ   = 4'd2,
    OP_BNZ  = 4'd3,
    OP_BC   = 4'd4,
    OP_BNC  = 4'd5,
    OP_JSB  = 4'd6,
    OP_RET  = 4'd7,
    OP_INT  = 4'd8,
    OP_RETI = 4'd9,
    OP_HOLD = 4'd10
  } pc_op_e;

  logic [AW-1:0]   pc_q, pc_d;
  logic [RSW-1:0]  rs_cnt_q, rs_cnt_d;
  logic [ISW-1:0]  is_cnt_q, is_cnt_d;
  logic            err_q, err_d;
  logic            rs_push, is_push;

  // Stack storage carries no reset; only entries below the depth are ever read.
  logic [AW-1:0]   rs_mem [RS_DEPTH];
  logic [AW+1:0]   is_mem [IS_DEPTH];

  logic            accept;
  logic [AW-1:0]   pc_inc, br_tgt, disp_ext;
  logic [RSIW-1:0] rs_wr_idx, rs_top_idx;
  logic [ISIW-1:0] is_wr_idx, is_top_idx;
  logic            rs_full, rs_empty, is_full, is_empty;
  logic [AW+1:0]   is_top;

  assign accept     = bus.clkEn_i & bus.PCEn_c;
  assign disp_ext   = {{(AW-DW){bus.disp_i[DW-1]}}, bus.disp_i};
  assign pc_inc     = pc_q + AW'(1);
  assign br_tgt     = pc_inc + disp_ext;

  assign rs_wr_idx  = RSIW'(rs_cnt_q);
  assign rs_top_idx = RSIW'(rs_cnt_q - RSW'(1));
  assign is_wr_idx  = ISIW'(is_cnt_q);
  assign is_top_idx = ISIW'(is_cnt_q - ISW'(1));
  assign rs_full    = (rs_cnt_q == RSW'(RS_DEPTH));
  assign rs_empty   = (rs_cnt_q == '0);
  assign is_full    = (is_cnt_q == ISW'(IS_DEPTH));
  assign is_empty   = (is_cnt_q == '0);
  assign is_top     = is_mem[is_top_idx];

  always_comb begin
    pc_d     = pc_q;
    rs_cnt_d = rs_cnt_q;
    is_cnt_d = is_cnt_q;
    err_d    = err_q;
    rs_push  = 1'b0;
    is_push  = 1'b0;
    case (pc_op_e'(bus.PCoper_i))
      OP_JMP:  pc_d = bus.addr_i;
      OP_BZ:   pc_d = bus.zero_i  ? br_tgt : pc_inc;
      OP_BNZ:  pc_d = !bus.zero_i ? br_tgt : pc_inc;
      OP_BC:   pc_d = bus.carry_i  ? br_tgt : pc_inc;
      OP_BNC:  pc_d = !bus.carry_i ? br_tgt : pc_inc;
      OP_JSB: begin
        if (rs_full) begin
          err_d = 1'b1;
        end else begin
          rs_push  = 1'b1;
          pc_d     = bus.addr_i;
          rs_cnt_d = rs_cnt_q + RSW'(1);
        end
      end
      OP_RET: begin
        if (rs_empty) begin
          err_d = 1'b1;
        end else begin
          pc_d     = rs_mem[rs_top_idx];
          rs_cnt_d = rs_cnt_q - RSW'(1);
        end
      end
      OP_INT: begin
        if (is_full) begin
          err_d = 1'b1;
        end else begin
          is_push  = 1'b1;
          pc_d     = ISR_VEC;
          is_cnt_d = is_cnt_q + ISW'(1);
        end
      end
      OP_RETI: begin
        if (is_empty) begin
          err_d = 1'b1;
        end else begin
          pc_d     = is_top[AW+1:2];
          is_cnt_d = is_cnt_q - ISW'(1);
        end
      end
      OP_HOLD: pc_d = pc_q;
      default: pc_d = pc_inc;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      pc_q     <= '0;
      rs_cnt_q <= '0;
      is_cnt_q <= '0;
      err_q    <= 1'b0;
    end else if (accept) begin
      pc_q     <= pc_d;
      rs_cnt_q <= rs_cnt_d;
      is_cnt_q <= is_cnt_d;
      err_q    <= err_d;
    end
  end

  // Writes are gated by rst so a reset overlapping an edge cannot leave a stray push.
  always_ff @(posedge clk_i) begin
    if (!rst && accept && rs_push) rs_mem[rs_wr_idx] <= pc_inc;
    if (!rst && accept && is_push) is_mem[is_wr_idx] <= {pc_q, bus.carry_i, bus.zero_i};
  end

  assign bus.PC_o      = pc_q;
  assign bus.rsDepth_o = rs_cnt_q;
  assign bus.isDepth_o = is_cnt_q;
  assign bus.stkErr_o  = err_q;
  assign bus.ccC_o     = !is_empty & is_top[1];
  assign bus.ccZ_o     = !is_empty & is_top[0];
endmodule

// File: doc/pc_seq_unit.md
PC_SEQ_UNIT -- requirements
Module: pc_seq_unit

Interface
REQ-001 Parameters SHALL be: AW, default 12, PC/address width; DW, default 8, branch displacement width (DW < AW); RS_DEPTH, default 8, return-stack entries (power of 2, >= 2); IS_DEPTH, default 2, interrupt-context entries (>= 1); ISR_VEC, default 12'h001, interrupt entry address (AW bits).
REQ-002 clk_i  in  1  single clock; all state updates on its rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 clkEn_i  in  1  clock enable; no state changes when 0.
REQ-005 PCoper_i  in  4  PC operation from control unit.
REQ-006 PCEn_c  in  1  PC write enable from control unit.
REQ-007 carry_i, zero_i  in  1 each  flag-register outputs.
REQ-008 disp_i  in  DW  signed branch displacement from the instruction register (IR).
REQ-009 addr_i  in  AW  absolute jump/call address from the IR.
REQ-010 PC_o  out  AW  current PC (registered).
REQ-011 ccC_o, ccZ_o  out  1 each  carry/zero saved in the top interrupt-context entry; 0 when the context stack is empty.
REQ-012 rsDepth_o  out  $clog2(RS_DEPTH+1)  return-stack occupancy.
REQ-013 isDepth_o  out  $clog2(IS_DEPTH+1)  interrupt-context occupancy.
REQ-014 stkErr_o  out  1  sticky overflow/underflow flag.

Function
REQ-015 An operation SHALL execute only in a cycle where clkEn_i=1 and PCEn_c=1; otherwise all state SHALL hold.
REQ-016 Encodings: 0 INC PC+1; 1 JMP addr_i; 2 BZ; 3 BNZ; 4 BC; 5 BNC; 6 JSB; 7 RET; 8 INT; 9 RETI; 10 HOLD; 11-15 SHALL behave as INC.
REQ-017 Branches (2-5): taken -> PC+1+sext(disp_i); not taken -> PC+1. Conditions: zero_i=1, zero_i=0, carry_i=1, carry_i=0 respectively.
REQ-018 All PC arithmetic SHALL be modulo 2^AW (wrap silently; 0xFFF+1 -> 0x000 at AW=12).
REQ-019 JSB: push PC+1 to the return stack, PC <= addr_i, depth+1.
REQ-020 RET: PC <= top of return stack, depth-1.
REQ-021 INT: push {PC_o, carry_i, zero_i} to the context stack, PC <= ISR_VEC, depth+1; the saved PC is the un-incremented PC_o.
REQ-022 RETI: PC <= saved PC, pop context, depth-1; ccC_o/ccZ_o then show the new top entry, or 0 when empty.
REQ-023 Full-stack JSB/INT and empty-stack RET/RETI SHALL leave PC, the stacks and the depths unchanged and set stkErr_o in the same edge.
REQ-024 stkErr_o SHALL clear only on reset.
REQ-025 Return and context stacks are independent; INT/RETI SHALL NOT alter the return stack, and JSB/RET SHALL NOT alter the context stack.
REQ-026 Latency: PC_o, the depth outputs and stkErr_o SHALL reflect an operation one clk_i edge after it is accepted; ccC_o/ccZ_o SHALL be registered-state outputs (no combinational path from inputs).
REQ-027 Stack contents beyond the current depth are don't-care and SHALL NOT be observable on any output.

Reset
REQ-028 On rst=1, without waiting for a clock edge: PC_o=0, rsDepth_o=0, isDepth_o=0, stkErr_o=0, ccC_o=0, ccZ_o=0.
REQ-029 Reset asserted mid-operation SHALL abort any pending update; after rst releases, the first accepted edge SHALL execute from PC 0.
REQ-030 Stack RAM contents SHALL NOT require reset.

Verification
REQ-031 Reset, then 3 INC with PCEn_c=1 and clkEn_i toggling 1,0,1,1 -> PC_o = 1, 1, 2, 3.
REQ-032 PC=0x010, BZ with disp=0xFE, zero_i=1 -> PC=0x00F; repeat with zero_i=0 -> PC=0x011; PC=0xFFF, INC -> PC=0x000.
REQ-033 Nested JSB to 0x100, 0x200, 0x300 from PC 0x005 -> rsDepth=3; three RETs -> PC 0x301, 0x201, 0x101 is wrong: required sequence is 0x201, 0x101, 0x006, then rsDepth=0.
REQ-034 RS_DEPTH+1 JSBs -> last one is ignored with PC unchanged and stkErr_o=1; a RET on an empty stack after reset -> PC holds and stkErr_o=1.
REQ-035 PC=0x040, carry_i=1, zero_i=0, INT -> PC=ISR_VEC, ccC_o=1, ccZ_o=0, isDepth=1; JSB/RET inside the ISR leave isDepth at 1; RETI -> PC=0x040, ccC_o=ccZ_o=0, isDepth=0.
REQ-036 Assert rst asynchronously between edges while rsDepth=2 -> all outputs are 0 immediately; after release the next INC gives PC=1.
